mdu: RTL and testbench

Multiply/divide unit for the EX stage of the pipelined CPU. It consumes the same operand pair as the ALU: A from the forwarded RS path and B from the ALU-B operand mux (RT or extended immediate). It executes MULT/MULTU/DIV/DIVU as multi-cycle operations with a Busy flag for the hazard unit, and holds the architectural HI/LO registers that MTHI/MTLO write and MFHI/MFLO read.

---
 rtl/mdu.sv | 134 +++++++++++++
 tb/tb_mdu.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// Module   : mdu
// Brief    : Multi-cycle multiply/divide unit holding the architectural HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Start,
    input  logic [1:0]  MDU_op,
    input  logic        MTHI,
    input  logic        MTLO,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [31:0]          r_hi, w_hi_nxt;
    logic [31:0]          r_lo, w_lo_nxt;
    logic [31:0]          r_pend_hi, w_pend_hi_nxt;
    logic [31:0]          r_pend_lo, w_pend_lo_nxt;
    logic                 r_commit_en, w_commit_en_nxt;

    // Result datapath: evaluated from the live operands, captured only on Start.
    logic        w_is_div;
    logic        w_signed;
    logic        w_a_neg, w_b_neg;
    logic [31:0] w_a_mag, w_b_mag, w_b_div;
    logic [31:0] w_q_mag, w_r_mag;
    logic [31:0] w_quot, w_rem;
    logic [63:0] w_a_ext, w_b_ext, w_prod;

    assign w_is_div = MDU_op[1];
    assign w_signed = ~MDU_op[0];

    // Division runs on magnitudes so that 0x80000000 / -1 wraps instead of trapping.
    assign w_a_neg = w_signed & A[31];
    assign w_b_neg = w_signed & B[31];
    assign w_a_mag = w_a_neg ? (32'd0 - A) : A;
    assign w_b_mag = w_b_neg ? (32'd0 - B) : B;
    assign w_b_div = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    assign w_q_mag = w_a_mag / w_b_div;
    assign w_r_mag = w_a_mag % w_b_div;
    assign w_quot  = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem   = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    // Low 64 bits of the extended product are correct for both signednesses.
    assign w_a_ext = {{32{w_signed & A[31]}}, A};
    assign w_b_ext = {{32{w_signed & B[31]}}, B};
    assign w_prod  = w_a_ext * w_b_ext;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_hi_nxt        = r_hi;
        w_lo_nxt        = r_lo;
        w_pend_hi_nxt   = r_pend_hi;
        w_pend_lo_nxt   = r_pend_lo;
        w_commit_en_nxt = r_commit_en;
        case (r_state)
            S_IDLE: begin
                if (MTHI) w_hi_nxt = A;
                if (MTLO) w_lo_nxt = A;
                if (Start) begin
                    w_state_nxt = S_BUSY;
                    if (w_is_div) begin
                        w_pend_hi_nxt   = w_rem;
                        w_pend_lo_nxt   = w_quot;
                        w_cnt_nxt       = c_CNT_W'(DIV_CYCLES);
                        w_commit_en_nxt = (B != 32'd0);
                    end else begin
                        w_pend_hi_nxt   = w_prod[63:32];
                        w_pend_lo_nxt   = w_prod[31:0];
                        w_cnt_nxt       = c_CNT_W'(MULT_CYCLES);
                        w_commit_en_nxt = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                w_cnt_nxt = r_cnt - c_CNT_W'(1);
                if (r_cnt == c_CNT_W'(1)) begin
                    w_state_nxt = S_IDLE;
                    if (r_commit_en) begin
                        w_hi_nxt = r_pend_hi;
                        w_lo_nxt = r_pend_lo;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_pend_hi   <= '0;
            r_pend_lo   <= '0;
            r_commit_en <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_hi        <= w_hi_nxt;
            r_lo        <= w_lo_nxt;
            r_pend_hi   <= w_pend_hi_nxt;
            r_pend_lo   <= w_pend_lo_nxt;
            r_commit_en <= w_commit_en_nxt;
        end
    end

    assign Busy = (r_state == S_BUSY);
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu
// Brief    : Directed self-checking bench for the mdu multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu;

    localparam int c_MULT_CYCLES = 5;
    localparam int c_DIV_CYCLES  = 10;
    localparam int c_TIMEOUT     = 50;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic        Start;
    logic [1:0]  MDU_op;
    logic        MTHI;
    logic        MTLO;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_vec;
    int n_err;

    mdu #(
        .MULT_CYCLES(c_MULT_CYCLES),
        .DIV_CYCLES (c_DIV_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .Start (Start),
        .MDU_op(MDU_op),
        .MTHI  (MTHI),
        .MTLO  (MTLO),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Pulses Start for one edge, then scrambles operands to show they are not re-sampled.
    // While busy, counts cycles and notes any HI/LO movement; optionally injects an
    // ignored Start+MTLO on busy cycle inject_at.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int inject_at, output int cycles, output logic changed);
        logic [31:0] hi0, lo0;
        hi0 = HI;
        lo0 = LO;
        @(negedge clk);
        A = a; B = b; MDU_op = op; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0; A = 32'hA5A5_A5A5; B = 32'h0000_0003;
        cycles  = 0;
        changed = 1'b0;
        while (Busy && cycles < c_TIMEOUT) begin
            cycles++;
            if (HI !== hi0 || LO !== lo0) changed = 1'b1;
            if (cycles == inject_at) begin
                Start = 1'b1; MDU_op = 2'b11; MTLO = 1'b1; A = 32'hDEAD_BEEF; B = 32'd9;
            end else begin
                Start = 1'b0; MTLO = 1'b0;
            end
            @(negedge clk);
        end
        Start = 1'b0; MTLO = 1'b0;
    endtask

    task automatic write_hilo(input logic hi_en, input logic lo_en, input logic [31:0] a);
        @(negedge clk);
        A = a; MTHI = hi_en; MTLO = lo_en;
        @(negedge clk);
        MTHI = 1'b0; MTLO = 1'b0;
    endtask

    int   cyc;
    logic chg;

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1; A = '0; B = '0; Start = 1'b0; MDU_op = 2'b00; MTHI = 1'b0; MTLO = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_busy", {31'd0, Busy}, 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);

        // MULT -3 * 5 = -15
        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0, cyc, chg);
        check("mult_busy_cycles", cyc, 32'd5);
        check("mult_hold", {31'd0, chg}, 32'd0);
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFF1);

        // MULTU 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
        run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 0, cyc, chg);
        check("multu_hi", HI, 32'h0000_0001);
        check("multu_lo", LO, 32'hFFFF_FFFE);

        // DIV -7 / 2 = -3 rem -1
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, cyc, chg);
        check("div_busy_cycles", cyc, 32'd10);
        check("div_hold", {31'd0, chg}, 32'd0);
        check("div_lo", LO, 32'hFFFF_FFFD);
        check("div_hi", HI, 32'hFFFF_FFFF);

        // DIVU 7 / 2 = 3 rem 1
        run_op(2'b11, 32'd7, 32'd2, 0, cyc, chg);
        check("divu_lo", LO, 32'd3);
        check("divu_hi", HI, 32'd1);

        // DIV overflow wraps
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, cyc, chg);
        check("divovf_lo", LO, 32'h8000_0000);
        check("divovf_hi", HI, 32'd0);

        // MTHI/MTLO then divide by zero
        write_hilo(1'b1, 1'b0, 32'h1111_1111);
        write_hilo(1'b0, 1'b1, 32'h2222_2222);
        check("mthi", HI, 32'h1111_1111);
        check("mtlo", LO, 32'h2222_2222);
        run_op(2'b10, 32'd5, 32'd0, 0, cyc, chg);
        check("div0_busy_cycles", cyc, 32'd10);
        check("div0_hi", HI, 32'h1111_1111);
        check("div0_lo", LO, 32'h2222_2222);

        // Simultaneous MTHI+MTLO
        write_hilo(1'b1, 1'b1, 32'h3333_4444);
        check("mthilo_hi", HI, 32'h3333_4444);
        check("mthilo_lo", LO, 32'h3333_4444);

        // Start/MTLO on busy cycle 2 must be ignored: 7 * 6 = 42
        run_op(2'b00, 32'd7, 32'd6, 2, cyc, chg);
        check("ign_busy_cycles", cyc, 32'd5);
        check("ign_hold", {31'd0, chg}, 32'd0);
        check("ign_hi", HI, 32'd0);
        check("ign_lo", LO, 32'd42);
        repeat (2) @(negedge clk);
        check("ign_no_relaunch", {31'd0, Busy}, 32'd0);

        // Reset during busy cycle 4 of a DIV
        @(negedge clk);
        A = 32'd100; B = 32'd7; MDU_op = 2'b10; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_busy_before", {31'd0, Busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_busy", {31'd0, Busy}, 32'd0);
        check("rst_mid_hi", HI, 32'd0);
        check("rst_mid_lo", LO, 32'd0);
        repeat (12) @(negedge clk);
        check("rst_nocommit_hi", HI, 32'd0);
        check("rst_nocommit_lo", LO, 32'd0);

        // Fresh MULT after reset: 3 * 4 = 12
        run_op(2'b00, 32'd3, 32'd4, 0, cyc, chg);
        check("post_rst_busy_cycles", cyc, 32'd5);
        check("post_rst_hi", HI, 32'd0);
        check("post_rst_lo", LO, 32'd12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
